// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryptor: one block per clock, 11-cycle latency.
// Every stage carries its own round key, so the key may change on every cycle.
module aes_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    // Standard AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry b sits at bit 2047 - 8*b, which is {~b, 3'b111}.
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Row ro of column c takes the byte from column (c + ro) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int ro = 0; ro < 4; ro++) begin
                r[127-8*(4*c+ro) -: 8] = s[127-8*(4*((c+ro)%4)+ro) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] data_q [10];
    logic [127:0] data_d [10];
    logic [127:0] key_q  [10];
    logic [127:0] key_d  [10];
    logic [127:0] round_key [10];
    logic [9:0]   valid_q, valid_d;
    logic [127:0] out_q, out_d;

    // round_key[s] is the key of round s+1, derived from the key held in stage s.
    always_comb begin
        for (int s = 0; s < 10; s++) begin
            round_key[s] = key_expand(key_q[s], RCON[79-8*s -: 8]);
        end
    end

    always_comb begin
        data_d[0] = state ^ key;
        key_d[0]  = key;
        for (int s = 1; s < 10; s++) begin
            data_d[s] = mix_columns(shift_rows(sub_bytes(data_q[s-1]))) ^ round_key[s-1];
            key_d[s]  = round_key[s-1];
        end
        valid_d = {valid_q[8:0], 1'b1};
        out_d   = valid_q[9] ? (shift_rows(sub_bytes(data_q[9])) ^ round_key[9]) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 10; s++) begin
                data_q[s] <= '0;
                key_q[s]  <= '0;
            end
            valid_q <= '0;
            out_q   <= '0;
        end else begin
            for (int s = 0; s < 10; s++) begin
                data_q[s] <= data_d[s];
                key_q[s]  <= key_d[s];
            end
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_aes_128.sv
// Directed and randomised bench for aes_128, with a reference model whose
// S-box is built from the GF(2^8) inverse and affine map.
module tb_aes_128;

    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         rst_n;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;

    logic [7:0]   tb_sbox [256];
    logic [127:0] exp_q [$];
    int           n_checks;
    int           n_errors;
    string        phase;

    aes_128 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .key   (key),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        return tb_sbox[b];
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sb(s[r][(c+r)%4]);
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
                    s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: out=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pipeline is empty after reset: the first ten results are zero.
    task automatic restart_expectations();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back('0);
    endtask

    task automatic stream_step(input logic [127:0] s, input logic [127:0] k, input logic [127:0] expv);
        state = s;
        key   = k;
        tick();
        exp_q.push_back(expv);
        if (exp_q.size() >= 11) check(phase, out, exp_q.pop_front());
    endtask

    task automatic random_step();
        logic [127:0] s, k;
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        stream_step(s, k, aes_model(s, k));
    endtask

    initial begin
        logic [7:0] inv;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        state    = '0;
        key      = '0;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            tb_sbox[a] = affine(inv);
        end

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", out, '0);
        end

        rst_n = 1'b1;
        restart_expectations();
        phase = "zero_vector";
        for (int i = 0; i < 12; i++) stream_step('0, '0, CT_Z);
        phase = "fips_appendix_b";
        for (int i = 0; i < 12; i++) stream_step(PT_A, KEY_A, CT_A);
        phase = "fips_appendix_c1";
        for (int i = 0; i < 12; i++) stream_step(PT_B, KEY_B, CT_B);
        phase = "alternating";
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) stream_step(PT_A, KEY_A, CT_A);
            else            stream_step(PT_B, KEY_B, CT_B);
        end
        phase = "random";
        for (int i = 0; i < 8; i++) random_step();

        rst_n = 1'b0;
        state = PT_A;
        key   = KEY_A;
        tick();
        check("reset_mid", out, '0);
        rst_n = 1'b1;
        restart_expectations();
        phase = "after_mid_reset";
        for (int i = 0; i < 12; i++) stream_step(PT_A, KEY_A, CT_A);
        phase = "random_model";
        for (int i = 0; i < 30; i++) random_step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
